// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares a single BRAM port between two requesters. At most one command is
// granted per cycle. Contention is resolved by a 1-bit round-robin pointer
// that always favours the requester that was not granted last time. The
// granted command is driven straight onto the BRAM port in the same cycle.
// Reads are tracked in a BRAM_LATENCY-deep valid/ID shift register so the read
// data can be steered back to the issuing requester when it emerges.
//
// Parameters
//   DATA_WIDTH   BRAM word width in bits
//   ADDR_WIDTH   BRAM address width in bits
//   BRAM_LATENCY BRAM read latency in cycles (legal range 1..8)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        requester N command handshake
//   reqN_we, reqN_addr, reqN_wdata requester N command
//   rspN_valid, rspN_rdata         requester N read response (no backpressure)
//   bram_en, bram_we, bram_addr,
//   bram_din                       BRAM port command
//   bram_dout                      BRAM read data
//   bram_rst                       BRAM output-register reset (mirrors rst)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BRAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  bram_rst
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    req_id_t ptr;
    logic    accept;
    req_id_t grant;

    logic    pipe_vld [BRAM_LATENCY];
    req_id_t pipe_id  [BRAM_LATENCY];

    // Ready is masked by rst combinationally so nothing is accepted while the
    // block is held in reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                req0_ready = (ptr == REQ0);
                req1_ready = (ptr == REQ1);
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign accept = req0_ready | req1_ready;
    assign grant  = req1_ready ? REQ1 : REQ0;

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = req0_addr;
        bram_din  = req0_wdata;
        if (req1_ready) begin
            bram_en   = 1'b1;
            bram_we   = req1_we;
            bram_addr = req1_addr;
            bram_din  = req1_wdata;
        end else if (req0_ready) begin
            bram_en   = 1'b1;
            bram_we   = req0_we;
            bram_addr = req0_addr;
            bram_din  = req0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ0;
            for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_id[i]  <= REQ0;
            end
        end else begin
            if (accept) begin
                ptr <= (grant == REQ1) ? REQ0 : REQ1;
            end
            pipe_vld[0] <= accept & ~bram_we;
            pipe_id[0]  <= grant;
            for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // The last shift-register stage lines up with the BRAM output, so the data
    // is passed through unconditionally and only the valid is steered.
    assign rsp0_valid = pipe_vld[BRAM_LATENCY-1] & (pipe_id[BRAM_LATENCY-1] == REQ0) & ~rst;
    assign rsp1_valid = pipe_vld[BRAM_LATENCY-1] & (pipe_id[BRAM_LATENCY-1] == REQ1) & ~rst;
    assign rsp0_rdata = bram_dout;
    assign rsp1_rdata = bram_dout;

    assign bram_rst = rst;

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the BRAM word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the BRAM address width in bits.
REQ-003 The block SHALL have parameter BRAM_LATENCY, default 2, giving the BRAM read latency in cycles; the legal range is 1..8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have ports req0_valid, input, 1 bit, and req0_ready, output, 1 bit: the requester-0 handshake.
REQ-007 The block SHALL have ports req0_we (input, 1), req0_addr (input, ADDR_WIDTH) and req0_wdata (input, DATA_WIDTH): the requester-0 command.
REQ-008 The block SHALL have ports rsp0_valid (output, 1) and rsp0_rdata (output, DATA_WIDTH): the requester-0 read response.
REQ-009 The block SHALL have ports req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid and rsp1_rdata, identical to requester 0 in direction and width.
REQ-010 The block SHALL have ports bram_en (output, 1), bram_we (output, 1), bram_addr (output, ADDR_WIDTH) and bram_din (output, DATA_WIDTH): the BRAM port command.
REQ-011 The block SHALL have port bram_dout, input, DATA_WIDTH: the BRAM read data.
REQ-012 The block SHALL have port bram_rst, output, 1 bit: the BRAM output-register reset.

Function
REQ-013 The block SHALL grant at most one request per cycle; a request is accepted in a cycle where reqN_valid and reqN_ready are both 1.
REQ-014 reqN_ready SHALL be combinational from the valid inputs and the priority pointer.
- Only one valid: that requester gets ready=1.
- Both valid: the requester named by the pointer gets ready=1.
- Neither valid: both readies are 0.
REQ-015 The priority pointer SHALL be a 1-bit register that, after any accept, points to the requester that was not granted; with no accept it holds.
REQ-016 In an accept cycle, the BRAM port SHALL be driven combinationally from the granted requester:
- bram_en = 1, bram_we = reqN_we, bram_addr = reqN_addr, bram_din = reqN_wdata.
- In non-accept cycles, bram_en = 0 and bram_we = 0.
REQ-017 For an accepted read (we = 0), the block SHALL record the requester ID in a BRAM_LATENCY-deep valid/ID shift register advancing every cycle.
REQ-018 rspN_valid SHALL pulse high for exactly one cycle, BRAM_LATENCY cycles after the accept cycle, with rspN_rdata = bram_dout in that cycle.
REQ-019 Only the requester that issued the read SHALL see rsp_valid; the other requester's rsp_valid stays 0.
REQ-020 rspN_rdata SHALL be bram_dout unconditionally; it is only meaningful while rspN_valid = 1.
REQ-021 Accepted writes SHALL produce no response.
REQ-022 Responses SHALL NOT be backpressured, and sustained throughput SHALL be one command per cycle.
REQ-023 Responses SHALL return in issue order; the block performs no forwarding, and read-after-write ordering follows BRAM semantics for the issue order.
REQ-024 A single requester holding valid continuously SHALL be accepted every cycle while the other requester is idle.
REQ-025 With both requesters valid every cycle, grants SHALL alternate 0,1,0,1..., starting from the pointer value.

Reset
REQ-026 bram_rst SHALL equal rst.
REQ-027 While rst = 1, the block SHALL hold:
- req0_ready = req1_ready = 0.
- bram_en = bram_we = 0.
- rsp0_valid = rsp1_valid = 0.
REQ-028 rst SHALL clear the pointer to 0 (requester 0 favoured) and clear the entire response shift register.
REQ-029 Reads in flight when rst asserts SHALL be discarded, with no response after reset deasserts.
REQ-030 The first accept SHALL be possible in the first cycle with rst = 0.

Verification
REQ-031 The bench SHALL cover a single read.
- Stimulus: BRAM_LATENCY=2; BRAM address 5 preloaded with 0xDEADBEEF; req0 read of address 5 in cycle T.
- Response: rsp0_valid=1 and rsp0_rdata=0xDEADBEEF in cycle T+2 only; rsp1_valid remains 0.
REQ-032 The bench SHALL cover contention.
- Stimulus: after reset, both requesters hold valid for 4 cycles.
- Response: grants go 0,1,0,1; bram_addr tracks the granted requester each cycle.
REQ-033 The bench SHALL cover a write followed by a read.
- Stimulus: req1 writes 0x12345678 to address 3; next cycle req1 reads address 3.
- Response: rsp1_rdata=0x12345678 BRAM_LATENCY cycles after the read accept; the write produces no response.
REQ-034 The bench SHALL cover back-to-back mixed reads.
- Stimulus: req0 and req1 alternate reads of addresses 0..7 with BRAM_LATENCY=3.
- Response: 8 responses, each delivered to the correct requester exactly 3 cycles after its accept, with correct data.
REQ-035 The bench SHALL cover reset mid-flight.
- Stimulus: req0 read accepted at T; rst=1 at T+1 for one cycle.
- Response: no rsp0_valid pulse; pointer reads 0, so a simultaneous request from both requesters at T+2 grants req0.
REQ-036 The bench SHALL cover a single requester streaming.
- Stimulus: req1 valid for 10 cycles; req0 idle.
- Response: req1_ready=1 in all 10 cycles; 10 bram_en cycles.
